mux16_arbitro: RTL and testbench

Round-robin arbiter that shares the 16:1 single-bit mux path between 16 requesters. It drives the mux select from a registered grant, holds each grant until release, requester drop or burst timeout, and rotates priority so no requester starves. It sits between the 16 requester channels and the shared `MUX16` instance, and routes the granted channel's data bit to one output.

---
 rtl/smsl_pkg.sv | 23 ++
 rtl/MUX16.sv | 13 +
 rtl/mux16_rr_picker.sv | 27 ++
 rtl/mux16_arbitro.sv | 100 ++++++++++
 tb/tb_mux16_arbitro.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/smsl_pkg.sv
// Shared definitions for the 16-channel mux arbitration slice.
// Channel count, select width, FSM encoding and a one-hot helper.
package smsl_pkg;

    localparam int N_CANALES = 16;
    localparam int ANCHO_SEL = 4;

    typedef enum logic {
        LIBRE     = 1'b0,
        CONCEDIDO = 1'b1
    } estado_t;

    // One-hot vector with only the given channel set.
    function automatic logic [N_CANALES-1:0] uno_caliente(
        input logic [ANCHO_SEL-1:0] idx
    );
        logic [N_CANALES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/MUX16.sv
// Shared 16:1 single-bit multiplexer.
// Purely combinational; the select is expected to come from a register.
module MUX16
    import smsl_pkg::*;
(
    input  logic [N_CANALES-1:0] D_i,
    input  logic [ANCHO_SEL-1:0] S_i,
    output logic                 Y_o
);

    assign Y_o = D_i[S_i];

endmodule

// File: rtl/mux16_rr_picker.sv
// Circular priority encoder for the round-robin arbiter.
// Scans upward from the pointer, wrapping 15 -> 0, first set bit wins.
module mux16_rr_picker
    import smsl_pkg::*;
(
    input  logic [N_CANALES-1:0] Solicitud,
    input  logic [ANCHO_SEL-1:0] puntero,
    output logic [ANCHO_SEL-1:0] ganador,
    output logic                 hay
);

    // Walk from farthest to nearest so the nearest set bit is the last write.
    always_comb begin
        logic [ANCHO_SEL-1:0] idx;
        ganador = '0;
        hay     = 1'b0;
        idx     = '0;
        for (int k = N_CANALES - 1; k >= 0; k--) begin
            idx = puntero + ANCHO_SEL'(k);
            if (Solicitud[idx]) begin
                ganador = idx;
                hay     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux16_arbitro.sv
// Round-robin arbiter sharing one 16:1 mux among 16 requesters.
// Registered grant and select; priority rotates past each winner.
module mux16_arbitro
    import smsl_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_CANALES-1:0] Solicitud,
    input  logic                 Fin,
    input  logic [N_CANALES-1:0] Dn,
    output logic [ANCHO_SEL-1:0] Seleccion,
    output logic [N_CANALES-1:0] Concesion,
    output logic                 Valido,
    output logic                 Ultimo,
    output logic                 Y
);

    localparam logic [7:0] MAX_C = 8'(MAX_BURST);

    estado_t              estado_q;
    logic [ANCHO_SEL-1:0] seleccion_q;
    logic [N_CANALES-1:0] concesion_q;
    logic [ANCHO_SEL-1:0] puntero_q;
    logic [7:0]           cuenta_q;

    logic [ANCHO_SEL-1:0] ganador;
    logic                 hay;
    logic                 tope;
    logic                 rel;
    logic                 y_mux;

    mux16_rr_picker u_picker (
        .Solicitud (Solicitud),
        .puntero   (puntero_q),
        .ganador   (ganador),
        .hay       (hay)
    );

    // Burst limit reached and combined release condition for the grant.
    always_comb begin
        tope = (cuenta_q == MAX_C);
        rel  = Fin | ~Solicitud[seleccion_q] | tope;
    end

    // Arbitration FSM: grant, hold, hand over without a gap, or go idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= LIBRE;
            seleccion_q <= '0;
            concesion_q <= '0;
            puntero_q   <= '0;
            cuenta_q    <= '0;
        end else begin
            unique case (estado_q)
                LIBRE: begin
                    if (hay) begin
                        estado_q    <= CONCEDIDO;
                        seleccion_q <= ganador;
                        concesion_q <= uno_caliente(ganador);
                        puntero_q   <= ganador + 4'd1;
                        cuenta_q    <= 8'd1;
                    end
                end
                CONCEDIDO: begin
                    if (!rel) begin
                        cuenta_q <= cuenta_q + 8'd1;
                    end else if (hay) begin
                        seleccion_q <= ganador;
                        concesion_q <= uno_caliente(ganador);
                        puntero_q   <= ganador + 4'd1;
                        cuenta_q    <= 8'd1;
                    end else begin
                        estado_q    <= LIBRE;
                        seleccion_q <= '0;
                        concesion_q <= '0;
                        cuenta_q    <= '0;
                    end
                end
                default: begin
                    estado_q <= LIBRE;
                end
            endcase
        end
    end

    MUX16 u_mux (
        .D_i (Dn),
        .S_i (seleccion_q),
        .Y_o (y_mux)
    );

    assign Seleccion = seleccion_q;
    assign Concesion = concesion_q;
    assign Valido    = (estado_q == CONCEDIDO);
    assign Ultimo    = Valido & tope;
    assign Y         = y_mux & Valido;

endmodule

// File: tb/tb_mux16_arbitro.sv
// Bench for mux16_arbitro: directed scenarios plus random traffic,
// each cycle compared against a behavioural round-robin model.
module tb_mux16_arbitro;

    localparam int MB = 4;

    logic        clk;
    logic        reset;
    logic [15:0] Solicitud;
    logic        Fin;
    logic [15:0] Dn;
    logic [3:0]  Seleccion;
    logic [15:0] Concesion;
    logic        Valido;
    logic        Ultimo;
    logic        Y;

    int n_cmp;
    int n_err;

    // Model state: who holds the path, for how long, and next priority.
    bit m_valid;
    int m_sel;
    int m_cnt;
    int m_ptr;

    mux16_arbitro #(.MAX_BURST(MB)) dut (
        .clk       (clk),
        .reset     (reset),
        .Solicitud (Solicitud),
        .Fin       (Fin),
        .Dn        (Dn),
        .Seleccion (Seleccion),
        .Concesion (Concesion),
        .Valido    (Valido),
        .Ultimo    (Ultimo),
        .Y         (Y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // First requester at or after ptr going upward with wrap, or -1.
    function automatic int pick(input logic [15:0] req, input int ptr);
        for (int k = 0; k < 16; k++) begin
            if (req[(ptr + k) % 16]) return (ptr + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [15:0] req, input bit fin,
                              input bit rst);
        int w;
        bit rel;
        w = pick(req, m_ptr);
        if (rst) begin
            m_valid = 0; m_sel = 0; m_cnt = 0; m_ptr = 0;
        end else if (!m_valid) begin
            if (w >= 0) begin
                m_valid = 1; m_sel = w; m_cnt = 1; m_ptr = (w + 1) % 16;
            end
        end else begin
            rel = fin || !req[m_sel] || (m_cnt == MB);
            if (!rel) begin
                m_cnt++;
            end else if (w >= 0) begin
                m_sel = w; m_cnt = 1; m_ptr = (w + 1) % 16;
            end else begin
                m_valid = 0; m_sel = 0; m_cnt = 0;
            end
        end
    endtask

    task automatic check_model();
        logic [15:0] conc;
        conc = m_valid ? (16'h1 << m_sel) : 16'h0;
        check("Valido", 16'(Valido), 16'(m_valid));
        check("Seleccion", 16'(Seleccion), m_valid ? 16'(m_sel) : 16'h0);
        check("Concesion", Concesion, conc);
        check("Ultimo", 16'(Ultimo), 16'(m_valid && m_cnt == MB));
        check("Y", 16'(Y), 16'(m_valid && Dn[m_sel]));
    endtask

    // Drive one cycle, compare before the edge, step model on the edge.
    task automatic cycle(input logic [15:0] req, input bit fin,
                         input logic [15:0] dn, input bit rst);
        @(negedge clk);
        Solicitud = req;
        Fin       = fin;
        Dn        = dn;
        reset     = rst;
        #1;
        check_model();
        @(posedge clk);
        model_step(req, fin, rst);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        Solicitud = 16'hFFFF;
        Fin = 1'b0;
        Dn = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        m_valid = 0; m_sel = 0; m_cnt = 0; m_ptr = 0;

        // Reset with all requesting, then first grant goes to 0.
        cycle(16'hFFFF, 0, 16'h0, 1);
        check("rst_valido", 16'(Valido), 16'h0);
        check("rst_conc", Concesion, 16'h0);
        cycle(16'hFFFF, 0, 16'hFFFF, 0);
        check("rst_sel0", 16'(Seleccion), 16'h0);
        check("rst_valid1", 16'(Valido), 16'h1);

        // Round robin across the wrap point.
        cycle(16'h8001, 0, 16'h0, 1);
        cycle(16'h8001, 1, 16'h0, 0);
        for (int i = 0; i < 4; i++) begin
            check("rr_sel", 16'(Seleccion), (i % 2) ? 16'd15 : 16'd0);
            cycle(16'h8001, 1, 16'h0, 0);
        end

        // Burst timeout with zero-gap handover.
        cycle(16'h0006, 0, 16'h0, 1);
        cycle(16'h0006, 0, 16'h0, 0);
        for (int i = 0; i < 8; i++) begin
            check("to_sel", 16'(Seleccion), (i < 4) ? 16'd1 : 16'd2);
            check("to_ult", 16'(Ultimo), 16'((i % 4) == 3));
            check("to_val", 16'(Valido), 16'h1);
            cycle(16'h0006, 0, 16'h0, 0);
        end

        // Requester drop ends the grant.
        cycle(16'h0020, 0, 16'h0, 1);
        cycle(16'h0020, 0, 16'hFFFF, 0);
        check("drop_sel", 16'(Seleccion), 16'd5);
        cycle(16'h0000, 0, 16'hFFFF, 0);
        check("drop_val", 16'(Valido), 16'h0);
        check("drop_y", 16'(Y), 16'h0);

        // Data routing follows Dn combinationally.
        cycle(16'h0200, 0, 16'h0, 1);
        cycle(16'h0200, 0, 16'h0200, 0);
        Dn = 16'h0200;
        #1;
        check("data_y1", 16'(Y), 16'h1);
        Dn = 16'hFDFF;
        #1;
        check("data_y0", 16'(Y), 16'h0);

        // Reset in the middle of a grant clears the pointer too.
        cycle(16'h0080, 0, 16'h0, 1);
        cycle(16'h0080, 0, 16'h0, 0);
        cycle(16'h0080, 0, 16'h0, 0);
        cycle(16'h0080, 0, 16'h0, 0);
        check("mid_sel7", 16'(Seleccion), 16'd7);
        cycle(16'h0080, 0, 16'h0, 1);
        check("mid_val", 16'(Valido), 16'h0);
        check("mid_sel", 16'(Seleccion), 16'h0);
        cycle(16'h0081, 0, 16'h0, 0);
        check("mid_win0", 16'(Seleccion), 16'd0);

        // Random traffic with sticky requests, strobes and rare resets.
        begin
            logic [15:0] req;
            req = 16'h0;
            for (int i = 0; i < 3000; i++) begin
                req = (req & 16'($urandom)) | (16'($urandom) & 16'($urandom)
                      & 16'($urandom));
                cycle(req, ($urandom % 4) == 0, 16'($urandom),
                      ($urandom % 97) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
